// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and default byte width.
package uart_pkg;

   localparam int DATA_W_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LAUNCH    = 2'd1,
      WAIT_DONE = 2'd2,
      HOLD      = 2'd3
   } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-side signals of the UART transmit arbiter.
// The arbiter connects through the slave modport; the requesters and transmitter use master.
interface uart_tx_arbiter_if
   import uart_pkg::*;
#(
   parameter int N_REQ  = 4,
   parameter int DATA_W = DATA_W_DEFAULT
) ();

   localparam int IDX_W = $clog2(N_REQ);

   logic [N_REQ-1:0]        req;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic [N_REQ-1:0]        req_last;
   logic [N_REQ-1:0]        gnt;
   logic [N_REQ-1:0]        ack;
   logic                    tx_start;
   logic [DATA_W-1:0]       tx_data;
   logic                    tx_busy;
   logic                    tx_done;
   logic [IDX_W-1:0]        owner_id;
   logic                    busy;

   modport slave (
      input  req, req_data, req_last, tx_busy, tx_done,
      output gnt, ack, tx_start, tx_data, owner_id, busy
   );

   modport master (
      output req, req_data, req_last, tx_busy, tx_done,
      input  gnt, ack, tx_start, tx_data, owner_id, busy
   );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin search: first set req bit at or above ptr, wrapping at N_REQ.
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic             valid,
   output logic [IDX_W-1:0] idx
);

   logic [IDX_W-1:0] cand [N_REQ];

   // cand[k] is the k-th requester visited when starting the search at ptr
   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
         assign cand[gi] = (int'(ptr) + gi >= N_REQ) ? IDX_W'(int'(ptr) + gi - N_REQ)
                                                      : IDX_W'(int'(ptr) + gi);
      end
   endgenerate

   always_comb begin
      valid = 1'b0;
      idx   = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (req[cand[k]]) begin
            valid = 1'b1;
            idx   = cand[k];
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding bytes from N_REQ requesters into one UART transmitter,
// keeping the grant locked to one requester until the last byte of its packet.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int DATA_W  = DATA_W_DEFAULT,
   parameter int LOCK_TO = 16
) (
   input logic              clk,
   input logic              rst,
   uart_tx_arbiter_if.slave bus
);

   localparam int IDX_W  = $clog2(N_REQ);
   localparam int HOLD_W = $clog2(LOCK_TO);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_REQ - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LOCK_TO - 1);

   arb_state_e        state_q, state_d;
   logic [IDX_W-1:0]  ptr_q, ptr_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              lock_n_q, lock_n_d;
   logic [N_REQ-1:0]  gnt_q, gnt_d;
   logic [N_REQ-1:0]  ack_q, ack_d;
   logic              tx_start_q, tx_start_d;
   logic [DATA_W-1:0] tx_data_q, tx_data_d;
   logic [IDX_W-1:0]  owner_q, owner_d;

   logic              pick_valid;
   logic [IDX_W-1:0]  pick_idx;
   logic              cap;
   logic              rel;
   logic [IDX_W-1:0]  cap_idx;
   logic [DATA_W-1:0] req_byte [N_REQ];

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_byte
         assign req_byte[gi] = bus.req_data[gi*DATA_W +: DATA_W];
      end
   endgenerate

   rr_pick #(
      .N_REQ (N_REQ)
   ) u_rr_pick (
      .req   (bus.req),
      .ptr   (ptr_q),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         hold_q     <= '0;
         lock_n_q   <= 1'b1;
         gnt_q      <= '0;
         ack_q      <= '0;
         tx_start_q <= 1'b0;
         tx_data_q  <= '0;
         owner_q    <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         hold_q     <= hold_d;
         lock_n_q   <= lock_n_d;
         gnt_q      <= gnt_d;
         ack_q      <= ack_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
         owner_q    <= owner_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      hold_d     = hold_q;
      lock_n_d   = lock_n_q;
      gnt_d      = gnt_q;
      ack_d      = '0;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      owner_d    = owner_q;
      cap        = 1'b0;
      rel        = 1'b0;
      cap_idx    = owner_q;

      unique case (state_q)
         IDLE: begin
            if (pick_valid) begin
               cap     = 1'b1;
               cap_idx = pick_idx;
            end
         end
         LAUNCH: begin
            if (!bus.tx_busy) begin
               tx_start_d = 1'b1;
               state_d    = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            // a done that coincides with our own launch pulse belongs to an earlier frame
            if (bus.tx_done && !tx_start_q) begin
               if (lock_n_q) begin
                  rel = 1'b1;
               end else if (bus.req[owner_q]) begin
                  cap = 1'b1;
               end else begin
                  hold_d  = '0;
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (bus.req[owner_q]) begin
               cap = 1'b1;
            end else if (hold_q == HOLD_MAX) begin
               rel = 1'b1;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (cap) begin
         state_d          = LAUNCH;
         tx_data_d        = req_byte[cap_idx];
         gnt_d            = '0;
         gnt_d[cap_idx]   = 1'b1;
         ack_d[cap_idx]   = 1'b1;
         owner_d          = cap_idx;
         lock_n_d         = bus.req_last[cap_idx];
      end

      // releasing owner moves to lowest priority for the next search
      if (rel) begin
         state_d = IDLE;
         gnt_d   = '0;
         ptr_d   = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
      end
   end

   assign bus.gnt      = gnt_q;
   assign bus.ack      = ack_q;
   assign bus.tx_start = tx_start_q;
   assign bus.tx_data  = tx_data_q;
   assign bus.owner_id = owner_q;
   assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a table of single-byte arbitrations followed by
// hand-written packet-lock, busy-stall, hold-timeout and mid-packet reset sequences.
module tb_uart_tx_arbiter;

   localparam int N    = 4;
   localparam int DW   = 8;
   localparam int LOCK = 16;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();

   uart_tx_arbiter #(
      .N_REQ   (N),
      .DATA_W  (DW),
      .LOCK_TO (LOCK)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [N-1:0]    req;
      logic [N*DW-1:0] data;
      int              owner;
      logic [DW-1:0]   byte_exp;
   } vec_t;

   vec_t vecs [11];
   int   checks   = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // launch then complete a byte whose owner has already been acked; ends released
   task automatic finish_byte(input string tag);
      tick();
      chk({tag, "_tx_start"}, 32'(bus.tx_start), 32'd1);
      tick();
      bus.tx_done = 1'b1;
      tick();
      bus.tx_done = 1'b0;
      chk({tag, "_gnt_release"}, 32'(bus.gnt), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      logic [N-1:0] oh;

      vecs[0]  = '{req: 4'b0100, data: 32'h33A51100, owner: 2, byte_exp: 8'hA5};
      vecs[1]  = '{req: 4'b1111, data: 32'h4C3B2A19, owner: 3, byte_exp: 8'h4C};
      vecs[2]  = '{req: 4'b1111, data: 32'h13121110, owner: 0, byte_exp: 8'h10};
      vecs[3]  = '{req: 4'b1111, data: 32'h23222120, owner: 1, byte_exp: 8'h21};
      vecs[4]  = '{req: 4'b1111, data: 32'h33323130, owner: 2, byte_exp: 8'h32};
      vecs[5]  = '{req: 4'b1111, data: 32'h43424140, owner: 3, byte_exp: 8'h43};
      vecs[6]  = '{req: 4'b1111, data: 32'h53525150, owner: 0, byte_exp: 8'h50};
      vecs[7]  = '{req: 4'b0001, data: 32'hFFFFFF7E, owner: 0, byte_exp: 8'h7E};
      vecs[8]  = '{req: 4'b1001, data: 32'hC8FFFF01, owner: 3, byte_exp: 8'hC8};
      vecs[9]  = '{req: 4'b0110, data: 32'h00B6E400, owner: 1, byte_exp: 8'hE4};
      vecs[10] = '{req: 4'b0011, data: 32'h0000F00D, owner: 0, byte_exp: 8'h0D};

      rst          = 1'b1;
      bus.req      = '0;
      bus.req_data = '0;
      bus.req_last = '0;
      bus.tx_busy  = 1'b0;
      bus.tx_done  = 1'b0;
      tick();
      tick();
      chk("rst_gnt",      32'(bus.gnt),      32'd0);
      chk("rst_ack",      32'(bus.ack),      32'd0);
      chk("rst_tx_start", 32'(bus.tx_start), 32'd0);
      chk("rst_tx_data",  32'(bus.tx_data),  32'd0);
      chk("rst_owner_id", 32'(bus.owner_id), 32'd0);
      chk("rst_busy",     32'(bus.busy),     32'd0);
      rst = 1'b0;

      // table: single-byte packets, round-robin pointer carried from vector to vector
      for (int i = 0; i < 11; i++) begin
         oh           = N'(1) << vecs[i].owner;
         bus.req      = vecs[i].req;
         bus.req_data = vecs[i].data;
         bus.req_last = '1;
         tick();
         chk("vec_ack",      32'(bus.ack),      32'(oh));
         chk("vec_gnt",      32'(bus.gnt),      32'(oh));
         chk("vec_owner_id", 32'(bus.owner_id), 32'(vecs[i].owner));
         chk("vec_tx_data",  32'(bus.tx_data),  32'(vecs[i].byte_exp));
         chk("vec_no_early_start", 32'(bus.tx_start), 32'd0);
         tick();
         chk("vec_tx_start", 32'(bus.tx_start), 32'd1);
         chk("vec_ack_pulse", 32'(bus.ack),     32'd0);
         tick();
         chk("vec_tx_start_pulse", 32'(bus.tx_start), 32'd0);
         bus.tx_done = 1'b1;
         tick();
         bus.tx_done = 1'b0;
         chk("vec_gnt_release",  32'(bus.gnt),  32'd0);
         chk("vec_busy_release", 32'(bus.busy), 32'd0);
         $display("txn vec%0d req=%b owner=%0d byte=%h", i, vecs[i].req, bus.owner_id, bus.tx_data);
      end

      // packet lock: requester 1 sends 0x11,0x22,0x33 while requester 0 waits
      bus.req      = 4'b0011;
      bus.req_data = 32'h0000110F;
      bus.req_last = 4'b0000;
      tick();
      chk("lock_ack1",  32'(bus.ack),     32'h2);
      chk("lock_data1", 32'(bus.tx_data), 32'h11);
      bus.req_data[15:8] = 8'h22;
      tick();
      chk("lock_start1", 32'(bus.tx_start), 32'd1);
      tick();
      bus.tx_done = 1'b1;
      tick();
      bus.tx_done = 1'b0;
      chk("lock_ack2",  32'(bus.ack),     32'h2);
      chk("lock_data2", 32'(bus.tx_data), 32'h22);
      chk("lock_gnt2",  32'(bus.gnt),     32'h2);
      bus.req_data[15:8] = 8'h33;
      bus.req_last[1]    = 1'b1;
      tick();
      chk("lock_start2", 32'(bus.tx_start), 32'd1);
      chk("lock_data2_stable", 32'(bus.tx_data), 32'h22);
      tick();
      bus.tx_done = 1'b1;
      tick();
      bus.tx_done = 1'b0;
      chk("lock_ack3",  32'(bus.ack),     32'h2);
      chk("lock_data3", 32'(bus.tx_data), 32'h33);
      bus.req      = 4'b0001;
      bus.req_last = 4'b1111;
      finish_byte("lock3");
      tick();
      chk("lock_next_gnt",  32'(bus.gnt),     32'h1);
      chk("lock_next_ack",  32'(bus.ack),     32'h1);
      chk("lock_next_data", 32'(bus.tx_data), 32'h0F);
      bus.req = '0;
      finish_byte("lock_next");
      $display("txn packet_lock owner=1 bytes=3 then owner=0");

      // busy stall with tx_done noise in LAUNCH and on the launch cycle
      bus.req      = 4'b0100;
      bus.req_data = 32'h005C0000;
      bus.req_last = 4'b1111;
      bus.tx_busy  = 1'b1;
      tick();
      chk("stall_ack", 32'(bus.ack), 32'h4);
      bus.req     = '0;
      bus.tx_done = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_no_start", 32'(bus.tx_start), 32'd0);
         chk("stall_tx_data",  32'(bus.tx_data),  32'h5C);
         chk("stall_gnt",      32'(bus.gnt),      32'h4);
      end
      bus.tx_busy = 1'b0;
      bus.tx_done = 1'b0;
      tick();
      chk("stall_start", 32'(bus.tx_start), 32'd1);
      bus.tx_done = 1'b1;
      tick();
      bus.tx_done = 1'b0;
      chk("stall_done_on_start_gnt",  32'(bus.gnt),  32'h4);
      chk("stall_done_on_start_busy", 32'(bus.busy), 32'd1);
      bus.tx_done = 1'b1;
      tick();
      bus.tx_done = 1'b0;
      chk("stall_release", 32'(bus.gnt), 32'd0);
      $display("txn busy_stall owner=2 byte=5c");

      // hold timeout: requester 3 leaves the packet open and goes quiet
      bus.req      = 4'b1000;
      bus.req_data = 32'h4000000A;
      bus.req_last = 4'b0000;
      tick();
      chk("hold_ack",  32'(bus.ack),     32'h8);
      chk("hold_data", 32'(bus.tx_data), 32'h40);
      bus.req      = 4'b0001;
      bus.req_last = 4'b0001;
      tick();
      chk("hold_start", 32'(bus.tx_start), 32'd1);
      tick();
      bus.tx_done = 1'b1;
      tick();
      bus.tx_done = 1'b0;
      chk("hold_enter_gnt",  32'(bus.gnt),  32'h8);
      chk("hold_enter_busy", 32'(bus.busy), 32'd1);
      for (int i = 1; i < LOCK; i++) begin
         tick();
         chk("hold_gnt_kept", 32'(bus.gnt), 32'h8);
      end
      tick();
      chk("hold_release_gnt",  32'(bus.gnt),  32'd0);
      chk("hold_release_busy", 32'(bus.busy), 32'd0);
      tick();
      chk("hold_next_gnt",  32'(bus.gnt),     32'h1);
      chk("hold_next_data", 32'(bus.tx_data), 32'h0A);
      bus.req = '0;
      finish_byte("hold_next");
      $display("txn hold_timeout owner=3 released after %0d cycles", LOCK);

      // reset while waiting for tx_done mid-packet
      bus.req      = 4'b0010;
      bus.req_data = 32'h00007700;
      bus.req_last = 4'b0000;
      tick();
      chk("rstmid_ack", 32'(bus.ack), 32'h2);
      tick();
      chk("rstmid_start", 32'(bus.tx_start), 32'd1);
      tick();
      #2;
      rst = 1'b1;
      #1;
      chk("rstmid_gnt",      32'(bus.gnt),      32'd0);
      chk("rstmid_ack0",     32'(bus.ack),      32'd0);
      chk("rstmid_tx_data",  32'(bus.tx_data),  32'd0);
      chk("rstmid_owner_id", 32'(bus.owner_id), 32'd0);
      chk("rstmid_busy",     32'(bus.busy),     32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rstmid_no_start", 32'(bus.tx_start), 32'd0);
      end
      rst          = 1'b0;
      bus.req      = 4'b1000;
      bus.req_data = 32'h99000000;
      bus.req_last = 4'b1111;
      tick();
      chk("rstmid_next_gnt",   32'(bus.gnt),      32'h8);
      chk("rstmid_next_owner", 32'(bus.owner_id), 32'd3);
      chk("rstmid_next_data",  32'(bus.tx_data),  32'h99);
      bus.req = '0;
      finish_byte("rstmid_next");
      $display("txn reset_mid_packet then owner=3 byte=99");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameters SHALL be:
- N_REQ, default 4: number of requesters (2..8).
- DATA_W, default 8: byte width.
- LOCK_TO, default 16: packet-lock hold timeout, in clk cycles.

REQ-002 Ports SHALL be:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req  in  N_REQ  per-requester byte request.
- req_data  in  N_REQ*DATA_W  per-requester byte; slice i belongs to requester i.
- req_last  in  N_REQ  offered byte is the last of its packet.
- gnt  out  N_REQ  one-hot current owner; all zero when no owner.
- ack  out  N_REQ  one-cycle pulse: owner's byte captured.
- tx_start  out  1  one-cycle launch pulse to the UART transmitter.
- tx_data  out  DATA_W  byte to transmit; stable from capture until tx_done.
- tx_busy  in  1  transmitter busy.
- tx_done  in  1  one-cycle pulse: transmitter finished the frame.
- owner_id  out  clog2(N_REQ)  index of the current or last owner.
- busy  out  1  high in every state except IDLE.

Function
REQ-003 FSM states SHALL be IDLE, LAUNCH, WAIT_DONE and HOLD.

REQ-004 IDLE:
- If any req bit is high, the winner SHALL be the first set bit found searching upward from ptr, wrapping at N_REQ.
- On that edge: latch the winner's req_data into tx_data; set gnt and owner_id; pulse ack for the winner; latch req_last into lock_n; go to LAUNCH.

REQ-005 LAUNCH:
- If tx_busy is 0, pulse tx_start for exactly one cycle and go to WAIT_DONE.
- Otherwise stay in LAUNCH with tx_start low.

REQ-006 WAIT_DONE:
- On tx_done with lock_n=1 (last byte sent): release. Clear gnt, set ptr to owner_id+1 mod N_REQ, go to IDLE.
- On tx_done with lock_n=0 and req[owner] high: capture the next byte as in REQ-004 (same owner), then go to LAUNCH.
- On tx_done with lock_n=0 and req[owner] low: clear the hold timer and go to HOLD.

REQ-007 HOLD:
- If req[owner] is high, capture its byte as in REQ-004 and go to LAUNCH.
- Otherwise increment the hold timer. When it reaches LOCK_TO-1, release as in REQ-006 without capturing.

REQ-008 Other requesters' req SHALL be ignored while an owner holds the lock; gnt SHALL NOT change in LAUNCH, WAIT_DONE or HOLD.

REQ-009 Latency:
- req sampled high in IDLE at edge t: ack, gnt and tx_data valid after edge t.
- tx_start asserted after edge t+1 if tx_busy=0.
- Minimum IDLE-to-tx_start is 2 cycles.

REQ-010 Requester rules:
- req_data and req_last SHALL be held stable while req is high and no ack has been received.
- After ack, the requester presents its next byte or drops req.

REQ-011 Boundary behaviour:
- tx_done is ignored in IDLE, LAUNCH and HOLD.
- tx_done in the same cycle as a tx_start pulse is ignored.
- Only the winner receives ack.
- req dropping during LAUNCH or WAIT_DONE does not abort the byte already captured.

REQ-012 Round-robin:
- ptr SHALL reset to 0 and update only on release.
- A requester that just released has the lowest priority at the next arbitration.

REQ-013 The hold timer SHALL be clog2(LOCK_TO) bits and SHALL NOT wrap.

Reset
REQ-014 While rst is high, and immediately on its assertion:
- state=IDLE, ptr=0, hold timer=0, lock_n=1.
- gnt=0, ack=0, tx_start=0, tx_data=0, owner_id=0, busy=0.

REQ-015 Reset asserted mid-byte or mid-packet SHALL abandon the transfer without a tx_start pulse. Arbitration after release SHALL restart with ptr=0.

Structure
REQ-016 The FSM state encoding and the default DATA_W SHALL reside in the shared package uart_pkg.

REQ-017 The round-robin search SHALL be a combinational sub-module rr_pick with inputs req and ptr and outputs valid and idx. All other logic is in uart_tx_arbiter.

Verification
REQ-018 Single byte: req[2]=1, req_last[2]=1, byte 0xA5, tx_busy=0. Required: ack[2] after 1 cycle; tx_start 1 cycle later with tx_data=0xA5; after tx_done, gnt=0 and ptr=3.

REQ-019 Fairness: req=4'b1111 held, all req_last=1. Required grant order 0,1,2,3,0; each requester sees one ack per round.

REQ-020 Packet lock: req[1] sends 0x11, 0x22, 0x33 with req_last set on 0x33 while req[0] is also high. Required: three consecutive tx_start pulses for requester 1, then grant to requester 0 with gnt=4'b0001.

REQ-021 Hold timeout: req[3] sends 0x40 with req_last=0, then drops req. Required: release exactly LOCK_TO cycles after tx_done; requester 0 is then granted.

REQ-022 Busy stall: tx_busy=1 for 5 cycles after capture. Required: tx_start stays low and is asserted in the cycle after tx_busy falls; tx_data unchanged throughout.

REQ-023 Reset mid-packet: assert rst in WAIT_DONE. Required: all outputs reach REQ-014 values with no further tx_start pulse; the next grant with req=4'b1000 goes to requester 3.
